// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Takes one command byte over a start/ready/done handshake, builds the
// 11-bit frame (start, 8 data LSB first, odd parity, stop), performs the
// request-to-send sequence on the open-drain clock/data pads and checks
// the device ACK.
//
// Optional feature macro: PS2_TX_RETRY_EN
//   When defined, a NACK or first-clock timeout is retried up to MAX_RETRY
//   times before the error is reported. When undefined, every error
//   finishes at once and retries stays 0.
//
// Ports
//   qzt_clk, rst_n     system clock, async active-low reset
//   tx_data, tx_start  command byte and request (accepted while ready=1)
//   ready, done        idle indicator, one-cycle end-of-transfer pulse
//   err, err_code      result of last transfer (00 ok, 01 first-clock
//                      timeout, 10 frame timeout, 11 NACK)
//   retries            retries used by the last transfer
//   ps2c_i, ps2d_i     asynchronous pad levels
//   ps2c_oe, ps2d_oe   1 = pull pad low, 0 = release
//   state              current FSM state (debug)
//
// state | meaning
// 0     | IDLE      waiting for tx_start
// 1     | INHIBIT   clock held low, start bit placed halfway through
// 2     | RELEASE   clock released, first-clock watchdog loaded
// 3     | SEND      data/parity/stop placed on device falling edges
// 4     | ACK       sample device ACK on 11th falling edge
// 5     | WAIT_IDLE wait for both lines high
// 6     | FINISH    issue done
// 7     | RETRY     both lines released before another request
module ps2_host_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int INHIBIT_US   = 100,
  parameter int FIRST_CLK_US = 15000,
  parameter int FRAME_US     = 2000,
  parameter int MAX_RETRY    = 2
) (
  input  logic       qzt_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ready,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [1:0] retries,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic [3:0] state
);

  localparam int CYC_PER_US    = CLK_HZ / 1_000_000;
  localparam int INHIBIT_CYC   = CYC_PER_US * INHIBIT_US;
  localparam int FIRST_CLK_CYC = CYC_PER_US * FIRST_CLK_US;
  localparam int FRAME_CYC     = CYC_PER_US * FRAME_US;
  localparam int T_MAX_A       = (INHIBIT_CYC > FIRST_CLK_CYC) ? INHIBIT_CYC : FIRST_CLK_CYC;
  localparam int T_MAX         = (T_MAX_A > FRAME_CYC) ? T_MAX_A : FRAME_CYC;
  localparam int TW            = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] INH_LOAD   = TW'(INHIBIT_CYC - 1);
  // Start bit goes out INHIBIT_CYC/2 cycles after the clock is pulled low.
  localparam logic [TW-1:0] INH_HALF   = TW'(INHIBIT_CYC - 1 - INHIBIT_CYC / 2);
  localparam logic [TW-1:0] FIRST_LOAD = TW'(FIRST_CLK_CYC - 1);
  localparam logic [TW-1:0] FRAME_LOAD = TW'(FRAME_CYC - 1);

  localparam logic [1:0] RETRY_LIMIT = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);
`ifdef PS2_TX_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INHIBIT   = 4'd1;
  localparam logic [3:0] S_RELEASE   = 4'd2;
  localparam logic [3:0] S_SEND      = 4'd3;
  localparam logic [3:0] S_ACK       = 4'd4;
  localparam logic [3:0] S_WAIT_IDLE = 4'd5;
  localparam logic [3:0] S_FINISH    = 4'd6;
  localparam logic [3:0] S_RETRY     = 4'd7;

  logic [3:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [9:0]    r_shift;
  logic [7:0]    r_data;
  logic [3:0]    r_bitcnt;
  logic          r_first;
  logic          r_c_oe, r_d_oe, r_done, r_err;
  logic [1:0]    r_err_code, r_retries;
  logic          r_c_meta, r_c_sync, r_c_sync_d, r_d_meta, r_d_sync;

  logic          w_fall, w_tc, w_fail, w_retry;
  logic [1:0]    w_fail_code;
  logic [9:0]    w_frame;

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_meta   <= 1'b1;
      r_c_sync   <= 1'b1;
      r_c_sync_d <= 1'b1;
      r_d_meta   <= 1'b1;
      r_d_sync   <= 1'b1;
    end else begin
      r_c_meta   <= ps2c_i;
      r_c_sync   <= r_c_meta;
      r_c_sync_d <= r_c_sync;
      r_d_meta   <= ps2d_i;
      r_d_sync   <= r_d_meta;
    end
  end

  assign w_fall  = r_c_sync_d & ~r_c_sync;
  assign w_tc    = (r_timer == '0);
  assign w_frame = {1'b1, ~^r_data, r_data};

  always_comb begin
    w_fail      = 1'b0;
    w_fail_code = 2'b00;
    case (r_state)
      S_SEND: begin
        if (!w_fall && w_tc) begin
          w_fail      = 1'b1;
          w_fail_code = r_first ? 2'b10 : 2'b01;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          if (r_d_sync) begin
            w_fail      = 1'b1;
            w_fail_code = 2'b11;
          end
        end else if (w_tc) begin
          w_fail      = 1'b1;
          w_fail_code = 2'b10;
        end
      end
      S_WAIT_IDLE: begin
        if (!(r_c_sync && r_d_sync) && w_tc) begin
          w_fail      = 1'b1;
          w_fail_code = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Frame timeouts are never retried; only NACK and first-clock timeout.
  assign w_retry = RETRY_EN && (w_fail_code != 2'b10) && (r_retries < RETRY_LIMIT);

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_shift    <= '1;
      r_data     <= '0;
      r_bitcnt   <= '0;
      r_first    <= 1'b0;
      r_c_oe     <= 1'b0;
      r_d_oe     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_retries  <= 2'b00;
    end else if (w_fail) begin
      r_c_oe <= 1'b0;
      r_d_oe <= 1'b0;
      if (w_retry) begin
        r_state   <= S_RETRY;
        r_timer   <= INH_LOAD;
        r_retries <= r_retries + 2'd1;
        r_shift   <= w_frame;
        r_bitcnt  <= '0;
        r_first   <= 1'b0;
      end else begin
        r_state    <= S_FINISH;
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_data     <= tx_data;
            r_shift    <= {1'b1, ~^tx_data, tx_data};
            r_bitcnt   <= '0;
            r_first    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_retries  <= 2'b00;
            r_timer    <= INH_LOAD;
            r_state    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          r_c_oe <= 1'b1;
          if (r_timer == INH_HALF) r_d_oe <= 1'b1;
          if (w_tc) r_state <= S_RELEASE;
          else      r_timer <= r_timer - TW'(1);
        end
        S_RELEASE: begin
          r_c_oe  <= 1'b0;
          r_timer <= FIRST_LOAD;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_fall) begin
            r_d_oe   <= ~r_shift[0];
            r_shift  <= {1'b1, r_shift[9:1]};
            r_bitcnt <= r_bitcnt + 4'd1;
            if (!r_first) begin
              r_first <= 1'b1;
              r_timer <= FRAME_LOAD;
            end else if (!w_tc) begin
              r_timer <= r_timer - TW'(1);
            end
            if (r_bitcnt == 4'd9) r_state <= S_ACK;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        S_ACK: begin
          if (w_fall) r_state <= S_WAIT_IDLE;
          else        r_timer <= r_timer - TW'(1);
        end
        S_WAIT_IDLE: begin
          if (r_c_sync && r_d_sync) r_state <= S_FINISH;
          else if (!w_tc)           r_timer <= r_timer - TW'(1);
        end
        S_FINISH: begin
          // Two cycles: done is raised in the second, ready the cycle after.
          if (!r_done) begin
            r_done <= 1'b1;
          end else begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RETRY: begin
          if (w_tc) begin
            r_timer <= INH_LOAD;
            r_state <= S_INHIBIT;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign retries  = r_retries;
  assign ps2c_oe  = r_c_oe;
  assign ps2d_oe  = r_d_oe;
  assign state    = r_state;

endmodule
